adder_exhaustive_checker: RTL and testbench
===========================================

# adder_exhaustive_checker

Sequential stimulus driver and error monitor for generated approximate adder netlists. Sweeps every operand pair of a WIDTH-bit adder into the combinational or pipelined approximate circuit, captures its sum, compares it against the exact sum, and accumulates error statistics. Results include the worst-case absolute error and an error-threshold (ET) verdict. It is the driving and observing end of the adder netlist interface, used in on-chip and emulation sign-off of XPAT-synthesised candidates.

## Interface
Parameters:
- WIDTH, 2, operand width; DUT has 2*WIDTH inputs.
- OUT_W, WIDTH+1, DUT sum width.
- ET, 1, error threshold; violation when |error| > ET.
- LAT, 0, DUT latency in cycles from dut_in change to valid dut_out (0 = combinational).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  begin sweep; sampled only in IDLE.
- dut_in  out  2*WIDTH  operand vector to DUT in0..in(2W-1); bits [WIDTH-1:0] = a, [2W-1:WIDTH] = b.
- dut_out  in  OUT_W  DUT sum out0..out(OUT_W-1), out0 = LSB.
- busy  out  1  sweep or drain in progress.
- done  out  1  one-cycle pulse; results valid from this cycle.
- err_count  out  2*WIDTH+1  number of vectors with nonzero error.
- max_err  out  OUT_W  maximum absolute error.
- sum_err  out  2*WIDTH+OUT_W  sum of absolute errors.
- et_viol  out  1  at least one vector with |error| > ET.
- first_viol  out  2*WIDTH  dut_in value of the first violating vector; 0 if none.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
- IDLE: start=1 clears all result outputs and the vector counter, then moves to SWEEP. dut_in holds its last value; it is 0 after reset.
- SWEEP: dut_in = vec, with vec incrementing 0..2^(2W)-1, one vector per cycle. After the last vector: go to DRAIN if LAT>0, else to DONE.
- Tag pipeline: a shift register, LAT+1 deep, carries {valid, vector} alongside the DUT. Capture uses the tag emerging at depth LAT.
- DRAIN: stays until the tag pipeline is empty; no new vectors issued.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Per captured vector:
  - exact = a + b, computed at OUT_W bits.
  - err = |dut_out − exact|, computed at OUT_W+1 bits signed; magnitude fits OUT_W.
  - err ≠ 0: err_count increments.
  - sum_err += err.
  - max_err = max(max_err, err).
  - err > ET and et_viol still 0: set et_viol and latch first_viol = tag vector.
- Results hold until the next accepted start.
- start while busy: ignored.
- start and rst in the same cycle: rst wins.
- rst mid-operation: FSM to IDLE, all outputs to reset values, partial statistics discarded, tag pipeline cleared.
- Counters cannot overflow: widths are sized for the all-vectors worst case.

## Timing
- Reset values: busy=0, done=0, dut_in=0, err_count=0, max_err=0, sum_err=0, et_viol=0, first_viol=0.
- Start accepted at edge E0 (cycle 0). busy=1 from cycle 1. Vector k is driven in cycle k+1.
- Vector k is sampled at the end of cycle k+1+LAT.
- done pulses in cycle N+LAT+1, where N = 2^(2W). Statistics are final in that same cycle.
- Earliest next start is accepted in cycle N+LAT+2.
- Output update latency: statistic outputs are registered and reflect a captured vector one cycle after its sample edge.

## Test plan
Default parameters (WIDTH=2, OUT_W=3, ET=1, LAT=0), N=16, unless stated.

- Exact adder as DUT, start pulse.
  - done in cycle 17.
  - err_count=0, max_err=0, sum_err=0, et_viol=0, first_viol=0.
- DUT tied to dut_out=0.
  - err_count=15, max_err=6, sum_err=48.
  - et_viol=1, first_viol=4'b0010 (a=2, b=0).
- DUT = exact sum with LSB inverted.
  - err_count=16, max_err=1, sum_err=16, et_viol=0.
- LAT=2, exact adder behind two register stages.
  - All statistics zero.
  - done in cycle 19; busy high cycles 1–18.
- rst asserted in cycle 8 of a sweep against the zero DUT.
  - Next cycle: all outputs at reset values, FSM in IDLE.
  - A fresh start then gives err_count=15, sum_err=48.
- start re-pulsed in cycles 5 and 10 mid-sweep.
  - No restart; done still in cycle 17 with unchanged results.
  - start in cycle 17 is ignored; start in cycle 18 is accepted and clears the statistics.

Source files
------------

// File: rtl/adder_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// adder_exhaustive_checker
//
// Drives every operand pair of a WIDTH-bit adder into an approximate adder
// netlist, captures the netlist's sum, compares it against the exact sum and
// accumulates error statistics (error count, worst-case and summed absolute
// error, error-threshold verdict and the first violating vector).
//
// Parameters:
//   WIDTH  operand width; the netlist has 2*WIDTH inputs
//   OUT_W  netlist sum width
//   ET     error threshold; a vector violates when |error| > ET
//   LAT    netlist latency in cycles (0 = combinational)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       begin a sweep (only honoured while idle)
//   dut_in      operand vector to the netlist: [WIDTH-1:0]=a, [2W-1:WIDTH]=b
//   dut_out     netlist sum, bit 0 = LSB
//   busy        sweep or drain in progress
//   done        one-cycle pulse, results valid from this cycle
//   err_count   number of vectors with nonzero error
//   max_err     maximum absolute error
//   sum_err     sum of absolute errors
//   et_viol     at least one vector exceeded ET
//   first_viol  dut_in of the first violating vector (0 if none)
// -----------------------------------------------------------------------------
module adder_exhaustive_checker #(
   parameter int WIDTH = 2,
   parameter int OUT_W = WIDTH + 1,
   parameter int ET    = 1,
   parameter int LAT   = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic [2*WIDTH-1:0]         dut_in,
   input  logic [OUT_W-1:0]           dut_out,
   output logic                       busy,
   output logic                       done,
   output logic [2*WIDTH:0]           err_count,
   output logic [OUT_W-1:0]           max_err,
   output logic [2*WIDTH+OUT_W-1:0]   sum_err,
   output logic                       et_viol,
   output logic [2*WIDTH-1:0]         first_viol
);

   localparam int VEC_W = 2 * WIDTH;
   localparam int CNT_W = 2 * WIDTH + 1;
   localparam int SUM_W = 2 * WIDTH + OUT_W;

   localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1'b1);
   localparam logic [VEC_W-1:0] VEC_LAST = {VEC_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [OUT_W-1:0] ET_L     = OUT_W'(ET);
   localparam bit               HAS_LAT  = (LAT > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               start_ok_s;
   logic               last_vec_s;
   logic               pending_s;

   logic [VEC_W-1:0]   dut_in_r;
   logic               busy_r;
   logic               done_r;

   // Tag entry i travels with the netlist; entry LAT lines up with dut_out.
   logic               tag_vld_r [0:LAT];
   logic [VEC_W-1:0]   tag_vec_r [0:LAT];

   logic               cap_vld_s;
   logic [VEC_W-1:0]   cap_vec_s;
   logic [WIDTH-1:0]   cap_a_s;
   logic [WIDTH-1:0]   cap_b_s;
   logic [OUT_W-1:0]   exact_s;
   logic [OUT_W-1:0]   abs_err_s;

   logic [CNT_W-1:0]   err_count_r;
   logic [OUT_W-1:0]   max_err_r;
   logic [SUM_W-1:0]   sum_err_r;
   logic               et_viol_r;
   logic [VEC_W-1:0]   first_viol_r;

   // Detect whether any vector is still in flight ahead of the capture point.
   always_comb begin
      pending_s = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         pending_s = pending_s | tag_vld_r[i];
      end
   end

   // Next-state logic of the sweep controller.
   always_comb begin
      state_s    = state_r;
      start_ok_s = 1'b0;
      last_vec_s = (dut_in_r == VEC_LAST);
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s    = ST_SWEEP;
               start_ok_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SWEEP: begin
            if (last_vec_s) begin
               state_s = HAS_LAT ? ST_DRAIN : ST_DONE;
            end else begin
               state_s = ST_SWEEP;
            end
         end
         ST_DRAIN: begin
            if (pending_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_DONE;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register plus busy/done, registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s == ST_SWEEP) || (state_s == ST_DRAIN);
         done_r  <= (state_s == ST_DONE);
      end
   end

   // Vector generator and tag pipeline; dut_in itself is the vector counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         dut_in_r <= {VEC_W{1'b0}};
         for (int i = 0; i <= LAT; i++) begin
            tag_vld_r[i] <= 1'b0;
            tag_vec_r[i] <= {VEC_W{1'b0}};
         end
      end else begin
         for (int i = 1; i <= LAT; i++) begin
            tag_vld_r[i] <= tag_vld_r[i-1];
            tag_vec_r[i] <= tag_vec_r[i-1];
         end
         if (start_ok_s) begin
            dut_in_r     <= {VEC_W{1'b0}};
            tag_vld_r[0] <= 1'b1;
            tag_vec_r[0] <= {VEC_W{1'b0}};
         end else if ((state_r == ST_SWEEP) && !last_vec_s) begin
            dut_in_r     <= dut_in_r + VEC_ONE;
            tag_vld_r[0] <= 1'b1;
            tag_vec_r[0] <= dut_in_r + VEC_ONE;
         end else begin
            tag_vld_r[0] <= 1'b0;
         end
      end
   end

   // Exact reference sum and absolute error of the vector at the capture point.
   always_comb begin
      cap_vld_s = tag_vld_r[LAT];
      cap_vec_s = tag_vec_r[LAT];
      cap_a_s   = cap_vec_s[WIDTH-1:0];
      cap_b_s   = cap_vec_s[VEC_W-1:WIDTH];
      exact_s   = OUT_W'(cap_a_s) + OUT_W'(cap_b_s);
      // Subtract the smaller from the larger so the magnitude stays unsigned.
      if (dut_out >= exact_s) begin
         abs_err_s = dut_out - exact_s;
      end else begin
         abs_err_s = exact_s - dut_out;
      end
   end

   // Error statistics; cleared by reset or an accepted start, held otherwise.
   always_ff @(posedge clk) begin
      if (rst || start_ok_s) begin
         err_count_r  <= {CNT_W{1'b0}};
         max_err_r    <= {OUT_W{1'b0}};
         sum_err_r    <= {SUM_W{1'b0}};
         et_viol_r    <= 1'b0;
         first_viol_r <= {VEC_W{1'b0}};
      end else if (cap_vld_s) begin
         if (abs_err_s != {OUT_W{1'b0}}) begin
            err_count_r <= err_count_r + CNT_ONE;
         end
         sum_err_r <= sum_err_r + SUM_W'(abs_err_s);
         if (abs_err_s > max_err_r) begin
            max_err_r <= abs_err_s;
         end
         // Only the first violation is recorded.
         if ((abs_err_s > ET_L) && !et_viol_r) begin
            et_viol_r    <= 1'b1;
            first_viol_r <= cap_vec_s;
         end
      end
   end

   assign dut_in     = dut_in_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err_count  = err_count_r;
   assign max_err    = max_err_r;
   assign sum_err    = sum_err_r;
   assign et_viol    = et_viol_r;
   assign first_viol = first_viol_r;

endmodule

// File: tb/tb_adder_exhaustive_checker.sv
// -----------------------------------------------------------------------------
// Testbench for adder_exhaustive_checker: one instance with a combinational
// netlist model (LAT=0) and one with a two-register-stage model (LAT=2).
// Netlist behaviour is selected by 'mode' (exact, zero, LSB-inverted, random
// lookup table); expected statistics come from a plain arithmetic sweep.
// -----------------------------------------------------------------------------
module tb_adder_exhaustive_checker;

   localparam int W  = 2;
   localparam int OW = 3;
   localparam int VW = 2 * W;
   localparam int NV = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start0, start2;
   logic [VW-1:0]    dut_in0, dut_in2, fv0, fv2;
   logic [OW-1:0]    dut_out0, dut_out2, maxe0, maxe2, p1, p2;
   logic             busy0, done0, busy2, done2, viol0, viol2;
   logic [VW:0]      errc0, errc2;
   logic [VW+OW-1:0] sume0, sume2;

   int mode;
   int sel;
   int lut [NV];
   int checks   = 0;
   int failures = 0;

   adder_exhaustive_checker #(.WIDTH(W), .OUT_W(OW), .ET(1), .LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
      .busy(busy0), .done(done0), .err_count(errc0), .max_err(maxe0),
      .sum_err(sume0), .et_viol(viol0), .first_viol(fv0)
   );

   adder_exhaustive_checker #(.WIDTH(W), .OUT_W(OW), .ET(1), .LAT(2)) u_lat2 (
      .clk(clk), .rst(rst), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
      .busy(busy2), .done(done2), .err_count(errc2), .max_err(maxe2),
      .sum_err(sume2), .et_viol(viol2), .first_viol(fv2)
   );

   // Behaviour of the netlist under test for operand vector v.
   function automatic int netlist_sum(input int m, input int v);
      int a, b;
      a = v % 4;
      b = v / 4;
      case (m)
         0:       return a + b;
         1:       return 0;
         2:       return (a + b) ^ 1;
         default: return lut[v];
      endcase
   endfunction

   assign dut_out0 = OW'(netlist_sum(mode, int'(dut_in0)));

   // Two register stages in front of the LAT=2 instance.
   always @(posedge clk) begin
      p1 <= OW'(netlist_sum(mode, int'(dut_in2)));
      p2 <= p1;
   end
   assign dut_out2 = p2;

   wire             busy_x = (sel == 0) ? busy0 : busy2;
   wire             done_x = (sel == 0) ? done0 : done2;
   wire [VW:0]      errc_x = (sel == 0) ? errc0 : errc2;
   wire [OW-1:0]    maxe_x = (sel == 0) ? maxe0 : maxe2;
   wire [VW+OW-1:0] sume_x = (sel == 0) ? sume0 : sume2;
   wire             viol_x = (sel == 0) ? viol0 : viol2;
   wire [VW-1:0]    fv_x   = (sel == 0) ? fv0   : fv2;

   task automatic check_val(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: sweep all vectors with plain arithmetic.
   task automatic model_stats(output int ec, output int mx, output int sm,
                              output int vi, output int fv);
      int e;
      ec = 0; mx = 0; sm = 0; vi = 0; fv = 0;
      for (int v = 0; v < NV; v++) begin
         e = netlist_sum(mode, v) - ((v % 4) + (v / 4));
         if (e < 0) e = -e;
         if (e != 0) ec++;
         sm += e;
         if (e > mx) mx = e;
         if (e > 1 && vi == 0) begin
            vi = 1;
            fv = v;
         end
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel == 0) start0 = v;
      else          start2 = v;
   endtask

   task automatic check_stats(input string tag);
      int ec, mx, sm, vi, fv;
      model_stats(ec, mx, sm, vi, fv);
      check_val({tag, " err_count"},  errc_x, ec);
      check_val({tag, " max_err"},    maxe_x, mx);
      check_val({tag, " sum_err"},    sume_x, sm);
      check_val({tag, " et_viol"},    viol_x, vi);
      check_val({tag, " first_viol"}, fv_x,   fv);
   endtask

   // Start a sweep, follow it to done; returns at the negedge of the done cycle.
   task automatic run_sweep(input int inst, input string tag, input bit repulse);
      int exp_done, busy_cnt, done_cyc;
      sel      = inst;
      exp_done = (inst == 0) ? NV + 1 : NV + 3;
      busy_cnt = 0;
      done_cyc = -1;
      @(negedge clk); drive_start(1'b1);
      @(negedge clk); drive_start(1'b0);
      for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (repulse) drive_start(cyc == 5 || cyc == 10);
         if (cyc == 1) check_val({tag, " busy_cycle1"}, busy_x, 1);
         if (busy_x) busy_cnt++;
         if (done_x) done_cyc = cyc;
      end
      check_val({tag, " done_cycle"}, done_cyc, exp_done);
      check_val({tag, " busy_cycles"}, busy_cnt, exp_done - 1);
      check_val({tag, " busy_at_done"}, busy_x, 0);
      check_stats(tag);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, " busy"},       busy_x, 0);
      check_val({tag, " done"},       done_x, 0);
      check_val({tag, " dut_in"},     (sel == 0) ? dut_in0 : dut_in2, 0);
      check_val({tag, " err_count"},  errc_x, 0);
      check_val({tag, " max_err"},    maxe_x, 0);
      check_val({tag, " sum_err"},    sume_x, 0);
      check_val({tag, " et_viol"},    viol_x, 0);
      check_val({tag, " first_viol"}, fv_x,   0);
   endtask

   initial begin
      int done_cyc;
      rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode = 0; sel = 0;
      for (int i = 0; i < NV; i++) lut[i] = 0;
      repeat (3) @(negedge clk);
      sel = 0; check_reset_vals("reset0");
      sel = 2; check_reset_vals("reset2");
      rst = 1'b0;

      mode = 0; run_sweep(0, "exact", 1'b0);
      mode = 1; run_sweep(0, "zero", 1'b0);
      mode = 2; run_sweep(0, "lsbinv", 1'b0);
      mode = 0; run_sweep(2, "lat2_exact", 1'b0);

      // Random approximate netlists, alternating between both latencies.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < NV; i++) lut[i] = $urandom_range(0, 7);
         mode = 3;
         run_sweep((r % 2 == 0) ? 0 : 2, $sformatf("rand%0d", r), 1'b0);
      end

      // Reset in cycle 8 of a sweep against the zero netlist.
      mode = 1; sel = 0;
      @(negedge clk); start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (6) @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_reset_vals("midrst");
      repeat (3) @(negedge clk);
      check_val("midrst idle_busy", busy0, 0);
      check_val("midrst idle_dut_in", dut_in0, 0);
      run_sweep(0, "after_rst", 1'b0);

      // Start re-pulsed mid-sweep, then held through the done and idle cycles.
      mode = 1;
      run_sweep(0, "repulse", 1'b1);
      start0 = 1'b1;
      @(negedge clk);
      check_val("repulse done_single", done0, 0);
      check_val("repulse start_in_done_ignored", busy0, 0);
      @(negedge clk); start0 = 1'b0;
      check_val("restart busy", busy0, 1);
      check_val("restart err_count_cleared", errc0, 0);
      check_val("restart sum_err_cleared", sume0, 0);
      check_val("restart et_viol_cleared", viol0, 0);
      check_val("restart dut_in", dut_in0, 0);
      done_cyc = -1;
      for (int cyc = 19; cyc <= 60 && done_cyc < 0; cyc++) begin
         if (cyc > 19) @(negedge clk);
         if (done0) done_cyc = cyc;
      end
      check_val("restart done_cycle", done_cyc, 35);
      check_stats("restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
